// File: rtl/stat_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stat_scheduler
// Purpose  : Serializes decay ticks and debounced user action pulses into a
//            single stream of stat increment/decrement commands, presented to
//            the stat register bank over a valid/ready handshake.
// Ports    : clk        - system clock
//            rst        - synchronous reset, active low
//            feeding    - pulse, food +1
//            healing    - pulse, health +1
//            play       - pulse, fun +1
//            sleeping   - pulse, sleep +1
//            test       - level, selects the fast prescaler divisor
//            upd_ready  - stat bank accepts the current command
//            upd_valid  - command presented
//            upd_sel    - stat index (0 food, 1 sleep, 2 fun, 3 health)
//            upd_inc    - 1 = +1, 0 = -1
//            tick       - one-cycle base-tick strobe
// Options  : STAT_SCHED_TEST_EN - when defined, test=1 switches the prescaler
//            to TEST_DIV from the next cycle; otherwise test is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module stat_scheduler #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned TEST_DIV      = 5_000_000,
  parameter int unsigned FOOD_PERIOD   = 8,
  parameter int unsigned SLEEP_PERIOD  = 12,
  parameter int unsigned FUN_PERIOD    = 6,
  parameter int unsigned HEALTH_PERIOD = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       feeding,
  input  logic       healing,
  input  logic       play,
  input  logic       sleeping,
  input  logic       test,
  input  logic       upd_ready,
  output logic       upd_valid,
  output logic [1:0] upd_sel,
  output logic       upd_inc,
  output logic       tick
);

  localparam int unsigned DIV_MAX = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
  localparam int unsigned CNT_W   = $clog2(DIV_MAX);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] SEL_FOOD   = 2'd0;
  localparam logic [1:0] SEL_SLEEP  = 2'd1;
  localparam logic [1:0] SEL_FUN    = 2'd2;
  localparam logic [1:0] SEL_HEALTH = 2'd3;

  // Reload values indexed by stat index
  localparam logic [3:0][7:0] RELOAD = {8'(HEALTH_PERIOD - 1), 8'(FUN_PERIOD - 1),
                                        8'(SLEEP_PERIOD - 1),  8'(FOOD_PERIOD - 1)};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_last;
  logic [3:0][7:0]  decay_q, decay_d;
  logic [3:0]       inc_pend_q, inc_pend_d;
  logic [3:0]       dec_pend_q, dec_pend_d;
  state_t           state_q, state_d;
  logic             upd_valid_q, upd_valid_d;
  logic [1:0]       upd_sel_q, upd_sel_d;
  logic             upd_inc_q, upd_inc_d;

  logic             tick_now;
  logic [3:0]       inc_set, dec_set;
  logic [3:0]       inc_clr, dec_clr;
  logic [1:0]       pick_sel;
  logic             pick_inc;

`ifdef STAT_SCHED_TEST_EN
  localparam logic [CNT_W-1:0] TEST_LAST = CNT_W'(TEST_DIV - 1);

  logic test_q, test_d;

  // The divisor follows the registered copy of test, so a change takes
  // effect one cycle after it is sampled.
  assign cnt_last = test_q ? TEST_LAST : TICK_LAST;
`else
  logic unused_test;

  assign unused_test = test;
  assign cnt_last    = TICK_LAST;
`endif

  // Stat index order: bit 0 food, 1 sleep, 2 fun, 3 health
  assign inc_set = {healing, play, sleeping, feeding};

  always_comb begin
`ifdef STAT_SCHED_TEST_EN
    test_d = test;
`endif
    // Prescaler: a count at or beyond the last value wraps; only an exact
    // match is a tick, so shrinking the divisor mid-count never double-ticks.
    tick_now = (cnt_q == cnt_last);
    cnt_d    = (cnt_q >= cnt_last) ? '0 : cnt_q + CNT_W'(1);

    // Decay down-counters
    decay_d = decay_q;
    dec_set = '0;
    if (tick_now) begin
      for (int i = 0; i < 4; i++) begin
        if (decay_q[i] == 8'd0) begin
          decay_d[i] = RELOAD[i];
          dec_set[i] = 1'b1;
        end else begin
          decay_d[i] = decay_q[i] - 8'd1;
        end
      end
    end

    // Fixed priority: user requests before decays
    pick_sel = SEL_HEALTH;
    pick_inc = 1'b0;
    if      (inc_pend_q[SEL_FOOD])   begin pick_sel = SEL_FOOD;   pick_inc = 1'b1; end
    else if (inc_pend_q[SEL_HEALTH]) begin pick_sel = SEL_HEALTH; pick_inc = 1'b1; end
    else if (inc_pend_q[SEL_FUN])    begin pick_sel = SEL_FUN;    pick_inc = 1'b1; end
    else if (inc_pend_q[SEL_SLEEP])  begin pick_sel = SEL_SLEEP;  pick_inc = 1'b1; end
    else if (dec_pend_q[SEL_FOOD])   begin pick_sel = SEL_FOOD;   pick_inc = 1'b0; end
    else if (dec_pend_q[SEL_SLEEP])  begin pick_sel = SEL_SLEEP;  pick_inc = 1'b0; end
    else if (dec_pend_q[SEL_FUN])    begin pick_sel = SEL_FUN;    pick_inc = 1'b0; end

    // Arbiter
    inc_clr     = '0;
    dec_clr     = '0;
    state_d     = state_q;
    upd_valid_d = upd_valid_q;
    upd_sel_d   = upd_sel_q;
    upd_inc_d   = upd_inc_q;
    if (state_q == IDLE) begin
      if ((|inc_pend_q) || (|dec_pend_q)) begin
        if (pick_inc) begin
          inc_clr[pick_sel] = 1'b1;
        end else begin
          dec_clr[pick_sel] = 1'b1;
        end
        upd_sel_d   = pick_sel;
        upd_inc_d   = pick_inc;
        upd_valid_d = 1'b1;
        state_d     = BUSY;
      end
    end else if (upd_ready) begin
      upd_valid_d = 1'b0;
      state_d     = IDLE;
    end

    // Set after clear: a new event in the grant cycle re-pends the source
    inc_pend_d = (inc_pend_q & ~inc_clr) | inc_set;
    dec_pend_d = (dec_pend_q & ~dec_clr) | dec_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef STAT_SCHED_TEST_EN
      test_q      <= 1'b0;
`endif
      cnt_q       <= '0;
      decay_q     <= RELOAD;
      inc_pend_q  <= '0;
      dec_pend_q  <= '0;
      state_q     <= IDLE;
      upd_valid_q <= 1'b0;
      upd_sel_q   <= 2'd0;
      upd_inc_q   <= 1'b0;
    end else begin
`ifdef STAT_SCHED_TEST_EN
      test_q      <= test_d;
`endif
      cnt_q       <= cnt_d;
      decay_q     <= decay_d;
      inc_pend_q  <= inc_pend_d;
      dec_pend_q  <= dec_pend_d;
      state_q     <= state_d;
      upd_valid_q <= upd_valid_d;
      upd_sel_q   <= upd_sel_d;
      upd_inc_q   <= upd_inc_d;
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_sel   = upd_sel_q;
  assign upd_inc   = upd_inc_q;
  assign tick      = tick_now;

endmodule
`default_nettype wire
